// File: rtl/rv_isa_pkg.sv
// Shared RV32I definitions for the instruction encoder: instruction formats,
// common opcodes, the canonical NOP and a range-check helper for immediates.
package rv_isa_pkg;

  // Instruction formats as presented on in_fmt; codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Encoder sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } enc_state_e;

  // Base opcodes of RV32I, for the loader and self-test sequencer.
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // addi x0, x0, 0 -- emitted in place of words with an unknown format.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when imm[31:top_lsb] are all copies of the sign bit, i.e. the value
  // survives truncation to a (top_lsb+1)-bit signed field.
  function automatic logic imm_fits(input logic [31:0] imm, input int top_lsb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= top_lsb && imm[i] != imm[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer: scatters the immediate into the bit positions of
// the selected format and reports whether the immediate was representable.
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  // Format-dependent packing and legality check.
  always_comb begin
    // NOTE: both outputs get a default before the case so no path leaves them
    // unassigned; that is what keeps this block free of inferred latches.
    instr = NOP_INSTR;
    err   = 1'b1;
    case (fmt)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !imm_fits(imm, 11);
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !imm_fits(imm, 11);
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = !imm_fits(imm, 12) || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = !imm_fits(imm, 20) || imm[0];
      end
      default: begin
        instr = NOP_INSTR;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: accepts decoded fields for a program of len words,
// emits packed instructions tagged with sequential word addresses through a
// single registered output stage, and tracks immediate/format errors.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic              done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  enc_state_e        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       pack_instr;
  logic              pack_err;
  logic              accept;
  logic              last_accept;

  instr_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  // Input is taken only while running and the output slot is free or leaving;
  // the combinational out_ready path is what gives one word per cycle.
  assign in_ready    = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((count + 1'b1) == len_q);
  assign busy        = (state != ST_IDLE);

  // Program sequencing, output register, address and length counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      count      <= '0;
      next_addr  <= BASE;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_addr   <= BASE;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees
      // the pre-edge value of the others regardless of statement order.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state      <= ST_RUN;
              len_q      <= len;
              count      <= '0;
              next_addr  <= BASE;
              err_sticky <= 1'b0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_instr <= pack_instr;
            out_err   <= pack_err;
            out_addr  <= next_addr;
            next_addr <= next_addr + 1'b1;
            count     <= count + 1'b1;
            if (pack_err) err_sticky <= 1'b1;
            if (last_accept) state <= ST_DRAIN;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
            done      <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, illegal
// immediates/formats, backpressure, random streams, wrap, len=0 and reset.
module tb_instr_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        out_err, err_sticky, done, busy;

  // Second instance: narrow address space starting near its top.
  logic        start2;
  logic [2:0]  len2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic        out_err2, err_sticky2, done2, busy2;

  item_t items[$];
  int    total = 0;
  int    bad   = 0;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky),
    .done(done), .busy(busy)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .len(len2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_addr(out_addr2), .out_err(out_err2), .err_sticky(err_sticky2),
    .done(done2), .busy(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoding from the ISA rules: signed ranges and field arithmetic.
  function automatic void ref_encode(input item_t it, output logic [31:0] ins, output logic e);
    logic [31:0] u, opp, rdp, rs1p, rs2p, f3p;
    longint      s;
    u    = it.imm;
    s    = longint'($signed(it.imm));
    opp  = 32'(it.op);
    rdp  = 32'(it.rd) << 7;
    f3p  = 32'(it.f3) << 12;
    rs1p = 32'(it.rs1) << 15;
    rs2p = 32'(it.rs2) << 20;
    case (it.fmt)
      3'd0: begin ins = (32'(it.f7) << 25) + rs2p + rs1p + f3p + rdp + opp; e = 1'b0; end
      3'd1: begin
        ins = ((u % 4096) << 20) + rs1p + f3p + rdp + opp;
        e   = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        ins = (((u / 32) % 128) << 25) + rs2p + rs1p + f3p + ((u % 32) << 7) + opp;
        e   = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        ins = (((u / 4096) % 2) << 31) + (((u / 32) % 64) << 25) + rs2p + rs1p + f3p
            + (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7) + opp;
        e   = (s < -4096) || (s > 4095) || ((u % 2) != 0);
      end
      3'd4: begin
        ins = (u - (u % 4096)) + rdp + opp;
        e   = (u % 4096) != 0;
      end
      3'd5: begin
        ins = (((u / 1048576) % 2) << 31) + (((u / 2) % 1024) << 21) + (((u / 2048) % 2) << 20)
            + (((u / 4096) % 256) << 12) + rdp + opp;
        e   = (s < -1048576) || (s > 1048575) || ((u % 2) != 0);
      end
      default: begin ins = 32'h0000_0013; e = 1'b1; end
    endcase
  endfunction

  function automatic item_t rand_item();
    item_t it;
    int    v;
    it.fmt = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    it.op  = 7'($urandom);
    it.rd  = 5'($urandom);
    it.rs1 = 5'($urandom);
    it.rs2 = 5'($urandom);
    it.f3  = 3'($urandom);
    it.f7  = 7'($urandom);
    case ($urandom_range(0, 3))
      0: it.imm = $urandom;
      1: begin v = int'($urandom_range(0, 8191)) - 4096; it.imm = 32'(v); end
      2: it.imm = $urandom & 32'hFFFF_F000;
      default: begin v = int'($urandom_range(0, 4095)) - 2048; it.imm = 32'(v) & ~32'h1; end
    endcase
    ref_encode(it, it.exp_instr, it.exp_err);
    return it;
  endfunction

  function automatic item_t mk(input int fmt, input int op, input int rd, input int rs1,
                               input int rs2, input int f3, input logic [31:0] imm,
                               input logic [31:0] ei, input logic ee);
    item_t it;
    it.fmt = 3'(fmt); it.op = 7'(op); it.rd = 5'(rd); it.rs1 = 5'(rs1);
    it.rs2 = 5'(rs2); it.f3 = 3'(f3); it.f7 = 7'd0; it.imm = imm;
    it.exp_instr = ei; it.exp_err = ee;
    return it;
  endfunction

  task automatic drive_item(input item_t it);
    in_fmt = it.fmt; in_opcode = it.op; in_rd = it.rd; in_rs1 = it.rs1;
    in_rs2 = it.rs2; in_funct3 = it.f3; in_funct7 = it.f7; in_imm = it.imm;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    len   = 9'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams items[] through the DUT. mode 0: full rate; 1: random valid/ready
  // plus a stray start pulse; 2: full rate with a 3-cycle downstream stall.
  task automatic run_stream(input int mode, input string tag);
    int          n, in_idx, out_idx, cyc, done_seen;
    logic        held;
    logic [31:0] h_instr;
    logic [7:0]  h_addr;
    n = items.size(); in_idx = 0; out_idx = 0; cyc = 0; done_seen = 0; held = 1'b0;
    h_instr = '0; h_addr = '0;
    do_start(n);
    while (out_idx < n && cyc < 3000) begin
      in_valid = (in_idx < n) && (mode != 1 || $urandom_range(0, 3) != 0);
      if (in_idx < n) drive_item(items[in_idx]);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(cyc >= 3 && cyc < 6);
      endcase
      start = (mode == 1 && cyc == 2);
      len   = 9'd1;
      #1;
      if (done) done_seen++;
      if (held) begin
        total++;
        if (out_valid !== 1'b1 || out_instr !== h_instr || out_addr !== h_addr) begin
          bad++;
          $display("FAIL %s hold: got v=%b %h@%0d want v=1 %h@%0d", tag, out_valid,
                   out_instr, out_addr, h_instr, h_addr);
        end
      end
      if (out_valid && !out_ready) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s in_ready during stall: got %b want 0", tag, in_ready);
        end
      end
      held = out_valid && !out_ready; h_instr = out_instr; h_addr = out_addr;
      if (out_valid && out_ready) begin
        total++;
        if (out_instr !== items[out_idx].exp_instr || out_addr !== 8'(out_idx)
            || out_err !== items[out_idx].exp_err) begin
          bad++;
          $display("FAIL %s word %0d: got %h@%0d err=%b want %h@%0d err=%b", tag, out_idx,
                   out_instr, out_addr, out_err, items[out_idx].exp_instr, out_idx,
                   items[out_idx].exp_err);
        end
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (out_idx != n || in_idx != n) begin
      bad++;
      $display("FAIL %s word count: got in=%0d out=%0d want %0d", tag, in_idx, out_idx, n);
    end
    if (mode != 1) begin
      total++;
      if (cyc != n + 1 + (mode == 2 ? 3 : 0)) begin
        bad++;
        $display("FAIL %s throughput: got %0d cycles want %0d", tag, cyc,
                 n + 1 + (mode == 2 ? 3 : 0));
      end
    end
    #1;
    total++;
    if (done_seen != 0 || done !== 1'b1) begin
      bad++;
      $display("FAIL %s done pulse: got early=%0d now=%b want early=0 now=1", tag, done_seen, done);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after done: got done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({out_valid, out_instr, out_addr, out_err, err_sticky, done, busy, in_ready} !==
        {1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset state: got v=%b i=%h a=%0d e=%b s=%b d=%b b=%b r=%b want all zero",
               out_valid, out_instr, out_addr, out_err, err_sticky, done, busy, in_ready);
    end
    total++;
    if (out_addr2 !== 2'd3) begin
      bad++;
      $display("FAIL reset base addr: got %0d want 3", out_addr2);
    end
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    start = 1'b1; len = 9'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL len0 first cycle: got done=%b busy=%b want 1 0", done, busy);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL len0 second cycle: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_directed();
    items.delete();
    items.push_back(mk(1, 7'h13, 1, 0, 0, 0, 32'd5,          32'h0050_0093, 1'b0));
    items.push_back(mk(2, 7'h23, 0, 1, 2, 2, 32'd8,          32'h0020_A423, 1'b0));
    items.push_back(mk(3, 7'h63, 0, 0, 0, 0, 32'hFFFF_FFFC,  32'hFE00_0EE3, 1'b0));
    items.push_back(mk(5, 7'h6F, 1, 0, 0, 0, 32'd2048,       32'h0010_00EF, 1'b0));
    items.push_back(mk(4, 7'h37, 5, 0, 0, 0, 32'h1234_5000,  32'h1234_52B7, 1'b0));
    run_stream(0, "directed");
    total++;
    if (err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL directed err_sticky: got %b want 0", err_sticky);
    end
  endtask

  task automatic test_illegal();
    items.delete();
    items.push_back(mk(1, 7'h13, 1, 0, 0, 0, 32'd2048, 32'h8000_0093, 1'b1));
    items.push_back(mk(3, 7'h63, 0, 0, 0, 0, 32'd3,    32'h0000_0163, 1'b1));
    items.push_back(mk(6, 7'h33, 3, 4, 5, 1, 32'd0,    32'h0000_0013, 1'b1));
    items.push_back(mk(7, 7'h6F, 9, 2, 7, 3, 32'd4,    32'h0000_0013, 1'b1));
    run_stream(0, "illegal");
    total++;
    if (err_sticky !== 1'b1) begin
      bad++;
      $display("FAIL illegal err_sticky: got %b want 1", err_sticky);
    end
  endtask

  task automatic test_err_clear();
    item_t it;
    items.delete();
    while (items.size() < 4) begin
      it = rand_item();
      if (!it.exp_err) items.push_back(it);
    end
    run_stream(0, "err_clear");
    total++;
    if (err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL err_sticky not cleared by start: got %b want 0", err_sticky);
    end
  endtask

  task automatic test_back_to_back(input int mode, input int n, input string tag);
    items.delete();
    for (int i = 0; i < n; i++) items.push_back(rand_item());
    run_stream(mode, tag);
  endtask

  task automatic test_wrap();
    item_t      w[3];
    logic [1:0] exp_addr[3];
    int         idx, got;
    exp_addr[0] = 2'd3; exp_addr[1] = 2'd0; exp_addr[2] = 2'd1;
    for (int i = 0; i < 3; i++) w[i] = rand_item();
    idx = 0; got = 0;
    @(negedge clk);
    start2 = 1'b1; len2 = 3'd3;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      in_valid2 = (idx < 3);
      if (idx < 3) drive_item(w[idx]);
      out_ready2 = 1'b1;
      #1;
      if (out_valid2) begin
        total++;
        if (out_addr2 !== exp_addr[got] || out_instr2 !== w[got].exp_instr) begin
          bad++;
          $display("FAIL wrap word %0d: got %h@%0d want %h@%0d", got, out_instr2, out_addr2,
                   w[got].exp_instr, exp_addr[got]);
        end
        got++;
      end
      if (in_valid2 && in_ready2) idx++;
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    total++;
    if (got != 3) begin
      bad++;
      $display("FAIL wrap word count: got %0d want 3", got);
    end
  endtask

  task automatic test_reset_mid_run();
    do_start(3);
    drive_item(mk(1, 7'h13, 1, 0, 0, 0, 32'd4096, 32'h0, 1'b1));
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || err_sticky !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre-reset setup: got v=%b s=%b b=%b want 1 1 1", out_valid, err_sticky, busy);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_instr, out_addr, out_err, err_sticky, done, busy, in_ready} !==
        {1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async reset: got v=%b i=%h a=%0d e=%b s=%b d=%b b=%b r=%b want all zero",
               out_valid, out_instr, out_addr, out_err, err_sticky, done, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    test_back_to_back(0, 4, "after_reset");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b1;
    start2 = 1'b0; len2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_len_zero();
    test_directed();
    test_illegal();
    test_err_clear();
    test_back_to_back(2, 8, "backpressure");
    for (int r = 0; r < 6; r++) test_back_to_back(1, 12, "random");
    test_back_to_back(0, 10, "full_rate");
    test_wrap();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
